// File: rtl/fifo_2_unpack.sv
// Pair-in / word-out FIFO: accepts (d1,d2) pairs and drains one word per pop, FWFT.
// Define FIFO2_UNPACK_HALF_ACCEPT_EN to store d1 alone when exactly one slot is free.
module fifo_2_unpack #(
    parameter int D_WIDTH    = 31,
    parameter int BUFF_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic [D_WIDTH-1:0]    d1,
    input  logic [D_WIDTH-1:0]    d2,
    output logic                  ready_in,
    output logic [D_WIDTH-1:0]    q,
    output logic                  valid,
    input  logic                  pop,
    output logic [BUFF_WIDTH:0]   count,
    output logic                  overflow
);
    localparam int DEPTH = 1 << BUFF_WIDTH;
    localparam logic [BUFF_WIDTH:0] DEPTH_C = (BUFF_WIDTH+1)'(DEPTH);

    logic [D_WIDTH-1:0]    mem [DEPTH];
    logic [BUFF_WIDTH-1:0] head, tail;
    logic [BUFF_WIDTH:0]   free, count_next;
    logic                  wr_pair, wr_half, pop_ok, drop;

    // Space is judged on the pre-edge count only; a same-cycle pop never makes room.
    assign free     = DEPTH_C - count;
    assign ready_in = (free >= (BUFF_WIDTH+1)'(2));
    assign valid    = (count != '0);
    assign q        = mem[tail];

    assign wr_pair = req & ready_in;
`ifdef FIFO2_UNPACK_HALF_ACCEPT_EN
    assign wr_half = req & (free == (BUFF_WIDTH+1)'(1));
`else
    assign wr_half = 1'b0;
`endif
    assign drop    = req & ~ready_in;
    assign pop_ok  = pop & valid;

    // wr_pair and wr_half are exclusive, so {wr_pair,wr_half} is the word count written.
    assign count_next = count + (BUFF_WIDTH+1)'({wr_pair, wr_half})
                              - (BUFF_WIDTH+1)'(pop_ok);

    always_ff @(posedge clk) begin
        if (!reset) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_pair)
                head <= head + BUFF_WIDTH'(2);
            else if (wr_half)
                head <= head + BUFF_WIDTH'(1);
            if (pop_ok)
                tail <= tail + BUFF_WIDTH'(1);
            if (drop)
                overflow <= 1'b1;
            count <= count_next;
        end
    end

    // Storage is never cleared; gating on reset keeps reset dominant over req.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (wr_pair || wr_half)
                mem[head] <= d1;
            if (wr_pair)
                mem[head + BUFF_WIDTH'(1)] <= d2;
        end
    end
endmodule

// File: tb/tb_fifo_2_unpack.sv
// Directed self-checking bench for fifo_2_unpack (depth 16, 31-bit words).
module tb_fifo_2_unpack;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req = 1'b0;
    logic [30:0] d1 = '0;
    logic [30:0] d2 = '0;
    logic        ready_in;
    logic [30:0] q;
    logic        valid;
    logic        pop = 1'b0;
    logic [4:0]  count;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    fifo_2_unpack #(.D_WIDTH(31), .BUFF_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .req(req), .d1(d1), .d2(d2),
        .ready_in(ready_in), .q(q), .valid(valid), .pop(pop),
        .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        repeat (n) tick();
        reset = 1'b1;
    endtask

    task automatic push(input logic [30:0] a, input logic [30:0] b);
        req = 1'b1; d1 = a; d2 = b;
        tick();
        req = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [30:0] exp);
        check({tag, "_valid"}, valid, 1);
        check({tag, "_q"}, q, exp);
        pop = 1'b1;
        tick();
        pop = 1'b0;
    endtask

    int          mcnt;
    logic        r;
    logic [30:0] nv;
    logic [30:0] sb [$];

    initial begin
        // Reset then a single pair
        do_reset(2);
        check("rst_count", count, 0);
        check("rst_valid", valid, 0);
        check("rst_ready", ready_in, 1);
        check("rst_ovf", overflow, 0);
        push(31'h11, 31'h22);
        check("p1_valid", valid, 1);
        check("p1_q", q, 31'h11);
        check("p1_count", count, 2);
        pop = 1'b1; tick(); pop = 1'b0;
        check("p1_q2", q, 31'h22);
        check("p1_count2", count, 1);
        pop = 1'b1; tick(); pop = 1'b0;
        check("p1_empty", valid, 0);
        check("p1_count3", count, 0);

        // Fill to full, then one more pair is dropped
        for (int i = 0; i < 8; i++) push(31'(2*i+1), 31'(2*i+2));
        check("full_count", count, 16);
        check("full_ready", ready_in, 0);
        check("full_ovf", overflow, 0);
        push(31'h99, 31'h98);
        check("ovf_count", count, 16);
        check("ovf_set", overflow, 1);
        for (int i = 1; i <= 16; i++) pop_chk("drain", 31'(i));
        check("drain_empty", valid, 0);
        check("drain_ovf_sticky", overflow, 1);

        // Random pairs with continuous pop; scoreboard model
        do_reset(1);
        mcnt = 0; nv = 31'h100;
        for (int c = 0; c < 300; c++) begin
            r = ($urandom_range(99) < 40) && (mcnt <= 14);
            req = r; d1 = nv; d2 = nv + 31'd1; pop = 1'b1;
            check("wrap_count", count, 64'(mcnt));
            check("wrap_valid", valid, 64'(mcnt > 0));
            if (mcnt > 0) begin
                check("wrap_q", q, sb[0]);
                void'(sb.pop_front());
                mcnt--;
            end
            if (r) begin
                sb.push_back(nv); sb.push_back(nv + 31'd1);
                nv += 31'd2; mcnt += 2;
            end
            tick();
        end
        req = 1'b0;
        while (mcnt > 0) begin
            check("wrap_dq", q, sb[0]);
            void'(sb.pop_front());
            mcnt--;
            tick();
        end
        pop = 1'b0;
        check("wrap_end_count", count, 0);
        check("wrap_ovf", overflow, 0);

        // Empty pops are ignored
        pop = 1'b1;
        repeat (5) tick();
        pop = 1'b0;
        check("epop_count", count, 0);
        check("epop_valid", valid, 0);
        push(31'h7, 31'h8);
        pop_chk("epop_a", 31'h7);
        pop_chk("epop_b", 31'h8);
        check("epop_done", valid, 0);

        // Simultaneous req+pop at count=15
        do_reset(1);
        for (int i = 0; i < 8; i++) push(31'(2*i+1), 31'(2*i+2));
        pop_chk("c15_first", 31'd1);
        check("c15_pre", count, 15);
        req = 1'b1; d1 = 31'h55; d2 = 31'h66; pop = 1'b1;
        tick();
        req = 1'b0; pop = 1'b0;
        check("c15_ovf", overflow, 1);
`ifdef FIFO2_UNPACK_HALF_ACCEPT_EN
        check("c15_count", count, 15);
        for (int i = 3; i <= 16; i++) pop_chk("c15_drain", 31'(i));
        pop_chk("c15_last", 31'h55);
`else
        check("c15_count", count, 14);
        for (int i = 3; i <= 16; i++) pop_chk("c15_drain", 31'(i));
`endif
        check("c15_empty", valid, 0);

        // Reset mid-operation overrides req and pop
        do_reset(1);
        push(31'h1, 31'h2); push(31'h3, 31'h4); push(31'h5, 31'h6);
        check("mid_count6", count, 6);
        reset = 1'b0; req = 1'b1; pop = 1'b1; d1 = 31'h33; d2 = 31'h44;
        tick();
        reset = 1'b1; req = 1'b0; pop = 1'b0;
        check("mid_count", count, 0);
        check("mid_valid", valid, 0);
        check("mid_ready", ready_in, 1);
        check("mid_ovf", overflow, 0);
        push(31'hA, 31'hB);
        pop_chk("mid_a", 31'hA);
        pop_chk("mid_b", 31'hB);
        check("mid_done", valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fifo_2_unpack.md
Name: fifo_2_unpack

Overview:
- Receive-side counterpart of the dual-push pair FIFO.
- Accepts a data pair (d1, d2) in any cycle where req is high. Stores the pair in order d1 then d2.
- Drains one word per accepted pop on a first-word-fall-through valid/pop interface.
- Sits between a pair-producing stage and a single-word consumer in the matrix datapath.

Parameters:
- D_WIDTH, 31, data word width in bits.
- BUFF_WIDTH, 4, log2 of storage depth; depth = 2^BUFF_WIDTH words (must be >= 2).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge).
- req  in  1  pair strobe; d1/d2 valid this cycle.
- d1  in  D_WIDTH  first word of pair (older).
- d2  in  D_WIDTH  second word of pair (younger).
- ready_in  out  1  combinational; 1 when free space >= 2 words.
- q  out  D_WIDTH  head-of-queue word, valid when valid=1.
- valid  out  1  combinational; 1 when count != 0.
- pop  in  1  consumer takes q this cycle when valid=1.
- count  out  BUFF_WIDTH+1  registered occupancy, 0 .. 2^BUFF_WIDTH.
- overflow  out  1  sticky; set when a pair (or half pair) is dropped.

Behaviour:
- Reset (reset=0 at an edge):
  - head, tail and count go to 0; overflow goes to 0.
  - Resulting outputs: valid=0, ready_in=1, q undefined (don't-care).
  - Reset overrides req and pop in the same cycle.
  - Storage contents are not cleared.
- Pointers:
  - head and tail are BUFF_WIDTH-bit and wrap modulo 2^BUFF_WIDTH.
  - count is kept separately so that full and empty are distinguishable.
- free = 2^BUFF_WIDTH - count, evaluated on the pre-edge count. ready_in = (free >= 2).
- Write path, on a req=1 edge:
  - If free >= 2: mem[head] <= d1, mem[head+1] <= d2 (wrapping), head <= head+2.
  - If free < 2: nothing is written, head is unchanged, overflow <= 1.
- Read path:
  - q = mem[tail] (first-word-fall-through).
  - On an edge with pop=1 and valid=1: tail <= tail+1.
  - pop with valid=0 is ignored; there is no error flag for it.
- Count update per edge: count_next = count + (2 if write accepted) - (1 if pop accepted).
- Simultaneous req and pop:
  - Both are honoured in the same edge.
  - Space is judged on the pre-edge count, so a pop in the same cycle does not create room. This is conservative.
  - At count = depth-1 with req=1 and pop=1: the pair is dropped, overflow is set, the pop proceeds, and count ends at depth-2.
- Latency:
  - A pair accepted at edge N gives valid=1 and q=d1 after edge N, when the queue was empty.
  - d2 becomes visible after the next accepted pop.
- Order: strict FIFO; words are popped as d1(pair0), d2(pair0), d1(pair1), ...
- overflow stays at 1 until reset; it does not affect normal operation.

Optional Feature:
- Macro: FIFO2_UNPACK_HALF_ACCEPT_EN.
- Defined: when free == 1 and req=1:
  - d1 is written at head, head <= head+1, count increments by 1.
  - d2 is dropped and overflow <= 1.
  - ready_in is unchanged (still requires free >= 2).
- Undefined: a pair is accepted only whole. With free == 1, both words are dropped and overflow is set.

Test Plan:
- Reset then one pair: reset=0 for 2 cycles, then req with d1=0x11, d2=0x22.
  - Next cycle: valid=1, q=0x11, count=2.
  - Pop: q=0x22, count=1.
  - Pop: valid=0, count=0.
- Fill to full (depth 16): 8 back-to-back reqs with values 1..16, no pops.
  - count=16, ready_in=0, overflow=0.
  - A 9th req leaves count=16 and sets overflow=1.
  - 16 pops return 1..16 in order, then valid=0.
- Wrap-around: 300 cycles of random req at 40% with continuous pop.
  - Output sequence equals input sequence.
  - head/tail wrap several times.
  - count never exceeds 16; overflow=0.
- Simultaneous req+pop at count=15:
  - Without the macro: the pair is dropped, overflow=1, count=14.
  - With FIFO2_UNPACK_HALF_ACCEPT_EN: d1 is stored, count=15, overflow=1, and the last popped word equals d1.
- Mid-operation reset: count=6, then reset=0 for one edge while req=1 and pop=1.
  - count=0, valid=0, ready_in=1, overflow=0.
  - The next pair 0xA/0xB pops as 0xA, 0xB.
- Empty pop: pop=1 for 5 cycles with count=0 leaves count=0 and tail unchanged. A subsequent pair pops correctly.
